// File: rtl/kbd_pkg.sv
// Scan-code / ASCII constants and the set-2 make-code to ASCII lookup.
// Shared by key_char_queue (optional caps lock: KEY_CHAR_CAPS_LOCK_EN).
package kbd_pkg;

    localparam logic [8:0] SC_LSHIFT   = 9'h012;
    localparam logic [8:0] SC_RSHIFT   = 9'h059;
    localparam logic [8:0] SC_CAPS     = 9'h058;
    localparam logic [8:0] SC_ENTER    = 9'h05A;
    localparam logic [8:0] SC_KP_ENTER = 9'h15A;
    localparam logic [8:0] SC_BKSP     = 9'h066;
    localparam logic [8:0] SC_SPACE    = 9'h029;

    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_BS = 8'h08;
    localparam logic [7:0] ASC_SP = 8'h20;

    // {hit, alphabet index 0..25}; extended codes never match
    function automatic logic [5:0] sc_letter(input logic [8:0] code9);
        logic       hit;
        logic [4:0] idx;
        hit = 1'b1;
        idx = 5'd0;
        case (code9)
            9'h01C: idx = 5'd0;   9'h032: idx = 5'd1;   9'h021: idx = 5'd2;
            9'h023: idx = 5'd3;   9'h024: idx = 5'd4;   9'h02B: idx = 5'd5;
            9'h034: idx = 5'd6;   9'h033: idx = 5'd7;   9'h043: idx = 5'd8;
            9'h03B: idx = 5'd9;   9'h042: idx = 5'd10;  9'h04B: idx = 5'd11;
            9'h03A: idx = 5'd12;  9'h031: idx = 5'd13;  9'h044: idx = 5'd14;
            9'h04D: idx = 5'd15;  9'h015: idx = 5'd16;  9'h02D: idx = 5'd17;
            9'h01B: idx = 5'd18;  9'h02C: idx = 5'd19;  9'h03C: idx = 5'd20;
            9'h02A: idx = 5'd21;  9'h01D: idx = 5'd22;  9'h022: idx = 5'd23;
            9'h035: idx = 5'd24;  9'h01A: idx = 5'd25;
            default: hit = 1'b0;
        endcase
        return {hit, idx};
    endfunction

    // {hit, digit 0..9}
    function automatic logic [4:0] sc_digit(input logic [8:0] code9);
        logic       hit;
        logic [3:0] idx;
        hit = 1'b1;
        idx = 4'd0;
        case (code9)
            9'h045: idx = 4'd0;  9'h016: idx = 4'd1;  9'h01E: idx = 4'd2;
            9'h026: idx = 4'd3;  9'h025: idx = 4'd4;  9'h02E: idx = 4'd5;
            9'h036: idx = 4'd6;  9'h03D: idx = 4'd7;  9'h03E: idx = 4'd8;
            9'h046: idx = 4'd9;
            default: hit = 1'b0;
        endcase
        return {hit, idx};
    endfunction

    function automatic logic [7:0] digit_sym(input logic [3:0] d);
        logic [7:0] ch;
        case (d)
            4'd0: ch = 8'h29;  4'd1: ch = 8'h21;  4'd2: ch = 8'h40;
            4'd3: ch = 8'h23;  4'd4: ch = 8'h24;  4'd5: ch = 8'h25;
            4'd6: ch = 8'h5E;  4'd7: ch = 8'h26;  4'd8: ch = 8'h2A;
            4'd9: ch = 8'h28;
            default: ch = 8'h00;
        endcase
        return ch;
    endfunction

    // {mapped, char}
    function automatic logic [8:0] sc_to_ascii(input logic [8:0] code9, input logic shift);
        logic [5:0] l;
        logic [4:0] d;
        logic       m;
        logic [7:0] ch;
        l  = sc_letter(code9);
        d  = sc_digit(code9);
        m  = 1'b1;
        ch = 8'h00;
        if (l[5]) begin
            ch = (shift ? 8'h41 : 8'h61) + 8'(l[4:0]);
        end else if (d[4]) begin
            ch = shift ? digit_sym(d[3:0]) : 8'h30 + 8'(d[3:0]);
        end else begin
            case (code9)
                SC_SPACE:              ch = ASC_SP;
                SC_ENTER, SC_KP_ENTER: ch = ASC_CR;
                SC_BKSP:               ch = ASC_BS;
                default:               m  = 1'b0;
            endcase
        end
        return {m, ch};
    endfunction

endpackage

// File: rtl/char_fifo.sv
// Synchronous FIFO with flush; flush beats push/pop, push when full needs a same-cycle pop.
module char_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata_c,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full_c,
    output logic                       empty_c
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty_c = (count == '0);
        full_c  = (count == (AW+1)'(DEPTH));
        do_pop  = pop & ~empty_c;
        do_push = push & (~full_c | do_pop);
        rdata_c = empty_c ? '0 : mem[rd_ptr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/key_char_queue.sv
// Turns decoder make events into shifted ASCII and queues them for a valid/ready consumer.
// Optional caps lock toggle on 9'h058 with KEY_CHAR_CAPS_LOCK_EN defined.
module key_char_queue
    import kbd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    input  logic [8:0]        last_change,
    input  logic [511:0]      key_down,
    input  logic              flush,
    input  logic              char_ready,
    output logic              char_valid,
    output logic [7:0]        char_data,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overflow
);
    logic       make;
    logic       shift;
    logic [8:0] lookup;
    logic       s0_load;
    logic       s1_valid;
    logic [7:0] s1_char;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
`ifdef KEY_CHAR_CAPS_LOCK_EN
    logic       caps;
    logic [5:0] letter;
`endif

    // Stage 0: classify the event and look up its character
    always_comb begin
        make  = key_down[last_change];
        shift = key_down[SC_LSHIFT] | key_down[SC_RSHIFT];
`ifdef KEY_CHAR_CAPS_LOCK_EN
        letter = sc_letter(last_change);
        lookup = sc_to_ascii(last_change, letter[5] ? (shift ^ caps) : shift);
`else
        lookup = sc_to_ascii(last_change, shift);
`endif
        s0_load = key_valid & make & lookup[8] & ~flush;
    end

`ifdef KEY_CHAR_CAPS_LOCK_EN
    // Caps survives flush; the toggle key itself never produces a character
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            caps <= 1'b0;
        end else if (key_valid && make && !flush && last_change == SC_CAPS) begin
            caps <= ~caps;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_char  <= 8'h00;
        end else begin
            s1_valid <= s0_load;
            if (s0_load) s1_char <= lookup[7:0];
        end
    end

    always_comb begin
        char_valid = ~fifo_empty;
        pop        = ~fifo_empty & char_ready;
    end

    // Sticky drop flag: a stage-1 character had nowhere to go
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (flush) begin
            overflow <= 1'b0;
        end else if (s1_valid && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

    char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .push    (s1_valid),
        .pop     (pop),
        .wdata   (s1_char),
        .rdata_c (char_data),
        .count   (fifo_count),
        .full_c  (fifo_full),
        .empty_c (fifo_empty)
    );

endmodule

// File: tb/tb_key_char_queue.sv
// Directed bench for key_char_queue with an expected-character scoreboard.
module tb_key_char_queue;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic [8:0]   last_change;
    logic [511:0] key_down;
    logic         flush;
    logic         char_ready;
    logic         char_valid;
    logic [7:0]   char_data;
    logic [4:0]   fifo_count;
    logic         overflow;

    logic [7:0] sb [$];
    logic [7:0] exp_c;
    int n_tests = 0;
    int n_fail  = 0;

    // Set-2 codes for 'a'..'z'
    logic [8:0] letters [26] = '{
        9'h01C, 9'h032, 9'h021, 9'h023, 9'h024, 9'h02B, 9'h034, 9'h033, 9'h043,
        9'h03B, 9'h042, 9'h04B, 9'h03A, 9'h031, 9'h044, 9'h04D, 9'h015, 9'h02D,
        9'h01B, 9'h02C, 9'h03C, 9'h02A, 9'h01D, 9'h022, 9'h035, 9'h01A};

    key_char_queue #(.FIFO_DEPTH(16), .ADDR_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .last_change (last_change),
        .key_down    (key_down),
        .flush       (flush),
        .char_ready  (char_ready),
        .char_valid  (char_valid),
        .char_data   (char_data),
        .fifo_count  (fifo_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [8:0] code);
        last_change = code;
        key_valid   = 1'b1;
        @(posedge clk); #1;
        key_valid   = 1'b0;
    endtask

    task automatic make(input logic [8:0] code, input logic mapped, input logic [7:0] ch);
        if (mapped) sb.push_back(ch);
        key_down[code] = 1'b1;
        pulse(code);
    endtask

    task automatic brk(input logic [8:0] code);
        key_down[code] = 1'b0;
        pulse(code);
    endtask

    task automatic tap(input logic [8:0] code, input logic mapped, input logic [7:0] ch);
        make(code, mapped, ch);
        brk(code);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain(input string tag);
        char_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (sb.size() == 0 && !char_valid) break;
            @(posedge clk); #1;
        end
        check(tag, 32'(sb.size() == 0 && !char_valid), 1);
        check({tag, "_count"}, fifo_count, 0);
    endtask

    // Consumer side: every accepted character must be the oldest expected one
    always @(negedge clk) begin
        if (!rst && char_valid && char_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 1);
            end else begin
                exp_c = sb.pop_front();
                check("char_data", char_data, exp_c);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        key_valid   = 1'b0;
        last_change = 9'h000;
        key_down    = '0;
        flush       = 1'b0;
        char_ready  = 1'b0;
        @(negedge clk);
        check("rst_valid", char_valid, 0);
        check("rst_data", char_data, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ovf", overflow, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);

        // Two-cycle latency from key_valid to char_valid
        char_ready = 1'b1;
        make(9'h01C, 1'b1, 8'h61);
        @(negedge clk);
        check("lat_t1", char_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("lat_t2", char_valid, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_count", fifo_count, 0);
        check("t1_valid", char_valid, 0);
        brk(9'h01C);

        // Shift, breaks, specials, extended, typematic repeat
        make(9'h012, 1'b0, 8'h00);
        make(9'h016, 1'b1, 8'h21);
        brk(9'h016);
        brk(9'h012);
        make(9'h059, 1'b0, 8'h00);
        tap(9'h01E, 1'b1, 8'h40);
        tap(9'h045, 1'b1, 8'h29);
        tap(9'h02D, 1'b1, 8'h52);
        brk(9'h059);
        tap(9'h029, 1'b1, 8'h20);
        tap(9'h05A, 1'b1, 8'h0D);
        tap(9'h15A, 1'b1, 8'h0D);
        tap(9'h066, 1'b1, 8'h08);
        tap(9'h11C, 1'b0, 8'h00);
        tap(9'h076, 1'b0, 8'h00);
        tap(9'h02D, 1'b1, 8'h72);
        tap(9'h046, 1'b1, 8'h39);
        make(9'h01C, 1'b1, 8'h61);
        make(9'h01C, 1'b1, 8'h61);
        brk(9'h01C);
        drain("t2_drain");

`ifdef KEY_CHAR_CAPS_LOCK_EN
        tap(9'h058, 1'b0, 8'h00);
        tap(9'h01C, 1'b1, 8'h41);
        make(9'h012, 1'b0, 8'h00);
        tap(9'h01C, 1'b1, 8'h61);
        brk(9'h012);
        tap(9'h016, 1'b1, 8'h31);
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        tap(9'h01C, 1'b1, 8'h41);
        tap(9'h058, 1'b0, 8'h00);
        tap(9'h01C, 1'b1, 8'h61);
`else
        tap(9'h058, 1'b0, 8'h00);
        tap(9'h01C, 1'b1, 8'h61);
`endif
        drain("caps_drain");

        // Overflow: 17 makes into a 16-deep queue with no consumer
        char_ready = 1'b0;
        for (int i = 0; i < 17; i++) tap(letters[i], i < 16, 8'(8'h61 + i));
        idle(2);
        check("t3_count", fifo_count, 16);
        check("t3_ovf", overflow, 1);
        check("t3_head", char_data, 8'h61);
        idle(3);
        check("t3_head_stable", char_data, 8'h61);
        drain("t3_drain");
        check("t3_ovf_sticky", overflow, 1);
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        @(negedge clk);
        check("t3_flush_ovf", overflow, 0);
        @(posedge clk); #1;

        // Full queue: push and pop on the same edge
        char_ready = 1'b0;
        for (int i = 0; i < 16; i++) tap(letters[i], 1'b1, 8'(8'h61 + i));
        idle(2);
        check("t4_full", fifo_count, 16);
        make(letters[25], 1'b1, 8'h7A);
        char_ready = 1'b1;
        @(posedge clk); #1;
        char_ready = 1'b0;
        @(negedge clk);
        check("t4_count", fifo_count, 16);
        check("t4_ovf", overflow, 0);
        @(posedge clk); #1;
        brk(letters[25]);
        drain("t4_drain");

        // Flush with 5 queued, one in stage 1 and one arriving
        char_ready = 1'b0;
        for (int i = 0; i < 5; i++) tap(letters[i], 1'b1, 8'(8'h61 + i));
        idle(1);
        make(letters[5], 1'b1, 8'h66);
        check("t5_pre_count", fifo_count, 5);
        flush = 1'b1;
        key_down[letters[6]] = 1'b1;
        last_change = letters[6];
        key_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        key_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        check("t5_count", fifo_count, 0);
        check("t5_ovf", overflow, 0);
        check("t5_valid", char_valid, 0);
        check("t5_data", char_data, 0);
        idle(3);
        check("t5_late_count", fifo_count, 0);
        check("t5_late_valid", char_valid, 0);
        brk(letters[5]);
        brk(letters[6]);
        drain("final_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/key_char_queue.md
Name: key_char_queue

Overview:
- Consumes the keyboard decoder's outputs (`key_valid` pulse, 9-bit `last_change` = {extend, code}, 512-bit `key_down` vector).
- Converts key-press (make) events into 8-bit ASCII characters, applying Shift state.
- Buffers characters in a small FIFO with a valid/ready output for text consumers (UI, display, game logic).
- Sits directly downstream of the keyboard decoder in the same clock domain.

Parameters:
- FIFO_DEPTH, 16, character FIFO depth (power of two, ≥2).
- ADDR_W, 4, log2(FIFO_DEPTH).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- key_valid  input  1  one-cycle pulse from decoder; `key_down` already updated in the same cycle.
- last_change  input  9  {extend, scan code set 2} of the event.
- key_down  input  512  pressed-key vector, indexed by {extend, code}.
- flush  input  1  synchronous clear of queue and overflow flag.
- char_ready  input  1  consumer accepts head character.
- char_valid  output  1  FIFO non-empty.
- char_data  output  8  ASCII at FIFO head; 8'h00 when empty.
- fifo_count  output  ADDR_W+1  current occupancy, 0..FIFO_DEPTH.
- overflow  output  1  sticky; a mapped character was dropped because the FIFO was full.

Behaviour:
- Reset (async): FIFO empty, pointers 0, `char_valid`=0, `char_data`=0, `fifo_count`=0, `overflow`=0, stage-1 register invalid, caps state 0.
- Stage 0, evaluated in the cycle `key_valid`=1:
  - make = `key_down[last_change]`; break events are ignored.
  - shift = `key_down[9'h012]` | `key_down[9'h059]`.
  - Lookup (non-extended unless stated):
    - Letters, codes 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A → 'a'..'z'; 'A'..'Z' when shift.
    - Digits, codes 45,16,1E,26,25,2E,36,3D,3E,46 → '0'..'9'; shifted → ) ! @ # $ % ^ & * (.
    - Space 29 → 8'h20.
    - Enter 5A and keypad Enter 1_5A → 8'h0D.
    - Backspace 66 → 8'h08.
    - All other codes are unmapped and dropped.
  - A mapped make loads the stage-1 register (`s1_valid`, `s1_char`) on that clock edge.
- Stage 1 to FIFO: write occurs on the next edge when `s1_valid`=1.
  - Latency: `key_valid` in cycle T → `char_valid`=1 in cycle T+2 (empty FIFO, no bypass).
- Typematic repeats (repeated make while held) each enqueue a character.
- Pop: when `char_valid` && `char_ready`, the head advances at the edge.
- Push when full: accepted only if a pop occurs in the same cycle. Otherwise the character is dropped and `overflow` is set on that edge.
- Simultaneous push and pop: count unchanged. Push into an empty FIFO with a pop in the same cycle is impossible, since `char_valid`=0.
- Pointers wrap modulo FIFO_DEPTH; count uses ADDR_W+1 bits.
- flush: on that edge, empties the FIFO, clears `overflow`, and invalidates `s1_valid`. `key_valid` in the same cycle as flush is discarded. flush has priority over push and pop.
- `char_data` is combinational from the head entry, gated to 0 when empty. It must stay stable while `char_valid`=1 and `char_ready`=0.

Optional Feature:
- Macro: KEY_CHAR_CAPS_LOCK_EN.
- With macro defined:
  - Make of 9'h058 toggles an internal `caps` register (reset 0); no character is enqueued.
  - Letters use upper case = shift XOR caps.
  - Digits and symbols ignore caps.
  - `caps` is not cleared by flush.
- Without macro: 9'h058 is unmapped; there is no `caps` register.

Decomposition:
- Package `kbd_pkg`:
  - Scan-code constants (SC_LSHIFT, SC_RSHIFT, SC_CAPS, SC_ENTER, SC_BKSP, SC_SPACE).
  - ASCII constants (ASC_CR, ASC_BS, ASC_SP).
  - Pure function `sc_to_ascii(code9, shift)` returning {mapped, char}.
- Sub-module `char_fifo`: synchronous FIFO (parameters DEPTH, WIDTH) with push/pop/flush, count, full/empty. The top level holds stage-0/1 logic, shift/caps, and overflow.

Test Plan:
- Make 9'h01C with no shift, `char_ready`=1 → `char_valid` at T+2, `char_data`=8'h61 for one cycle, `fifo_count` returns to 0.
- Hold 9'h012 down, make 9'h016 → 8'h21 ('!'); break of 9'h016 → nothing enqueued.
- `char_ready`=0, 17 mapped makes (FIFO_DEPTH=16) → `fifo_count`=16, `overflow`=1, first 16 chars drained in order.
- FIFO full, push and pop in the same cycle → count stays 16, `overflow` stays 0, new char appears last.
- flush asserted with `s1_valid`=1 and 5 entries queued → `fifo_count`=0, `overflow`=0, no late write.
- KEY_CHAR_CAPS_LOCK_EN: make 9'h058, then 9'h01C → 8'h41; shift+9'h01C → 8'h61; 9'h016 → 8'h31.
